// File: rtl/mbledhesi_pipeline.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry registered between stages.
// Optional signed saturation on the final result when MBLEDHESI_SAT_EN is defined.
module mbledhesi_pipeline #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] REZ,
    output logic             CarryOut,
    output logic             OVF,
    output logic             ZERO
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Handshake: a beat moves when valid and ready are both high at a rising edge.
    // Every register advances together on w_adv; a stalled output freezes the whole pipe.
    logic             w_adv;

    // Register k holds operands, sum slices 0..k-1 and the carry into slice k.
    logic             r_v   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];

    logic [CHUNK:0]   w_add [STAGES];
    logic [WIDTH-1:0] w_sum [STAGES];

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_rez;
    logic             w_cout;
    logic             w_msb_carry;
    logic             w_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_rez;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_adv     = OUT_READY | ~r_out_valid;
    assign IN_READY  = w_adv;
    assign OUT_VALID = r_out_valid;
    assign REZ       = r_rez;
    assign CarryOut  = r_cout;
    assign OVF       = r_ovf;
    assign ZERO      = r_zero;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_add[k] = {1'b0, r_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, r_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, r_c[k]};
            w_sum[k] = r_sum[k];
            w_sum[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
        end
    end

    assign w_res  = w_sum[LAST];
    assign w_cout = w_add[LAST][CHUNK];
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign w_msb_carry = r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ w_res[WIDTH-1];
    assign w_ovf       = w_msb_carry ^ w_cout;

`ifdef MBLEDHESI_SAT_EN
    always_comb begin
        w_rez = w_res;
        if (w_ovf) begin
            w_rez = r_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_rez = w_res;
`endif

    // Control and result state: cleared on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_rez       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            r_v[0] <= IN_VALID;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k] <= r_v[k-1];
            end
            r_out_valid <= r_v[LAST];
            if (r_v[LAST]) begin
                r_rez  <= w_rez;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_rez == '0);
            end
        end
    end

    // Datapath skew registers: meaningless unless the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_a[0]   <= A;
            r_b[0]   <= SUB ? ~B : B;
            r_c[0]   <= SUB ? ~CIN : CIN;
            r_sum[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_c[k]   <= w_add[k-1][CHUNK];
                r_sum[k] <= w_sum[k-1];
            end
        end
    end

endmodule

// File: tb/tb_mbledhesi_pipeline.sv
// Self-checking bench for mbledhesi_pipeline (WIDTH=16, CHUNK=4): directed cases, streaming,
// stall, reset flush and random back-pressure, all checked through an expected-result queue.
module tb_mbledhesi_pipeline;

    localparam int W  = 16;
    localparam int EW = W + 3;

    logic         CLK;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         SUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] REZ;
    logic         CarryOut;
    logic         OVF;
    logic         ZERO;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_popped = 0;

    mbledhesi_pipeline #(.WIDTH(16), .CHUNK(4)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .REZ(REZ), .CarryOut(CarryOut), .OVF(OVF), .ZERO(ZERO)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: packs {rez, carry, ovf, zero}
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        logic [W:0]   full;
        logic [W-1:0] rez;
        int sa, sb, sr;
        logic ovf;
        if (!sub) full = {1'b0, a} + {1'b0, b} + 17'(cin);
        else      full = {1'b0, a} + {1'b0, ~b} + 17'(!cin);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        sr  = sub ? (sa - sb - int'(cin)) : (sa + sb + int'(cin));
        ovf = (sr > 32767) || (sr < -32768);
        rez = full[W-1:0];
`ifdef MBLEDHESI_SAT_EN
        if (ovf) rez = (sa >= 0) ? 16'h7FFF : 16'h8000;
`endif
        return {rez, full[W], ovf, (rez == '0)};
    endfunction

    // Scoreboard monitor: compares every delivered beat against the queue head
    always @(negedge CLK) begin
        if (RST === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_beat: got REZ=%h with no beat outstanding", REZ);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({REZ, CarryOut, OVF, ZERO} !== e)
                    begin
                        n_errors++;
                        $display("FAIL scoreboard: got REZ=%h C=%b V=%b Z=%b, expected REZ=%h C=%b V=%b Z=%b",
                                 REZ, CarryOut, OVF, ZERO, e[EW-1:3], e[2], e[1], e[0]);
                    end
            end
            n_popped++;
        end
    end

    // Driver: call at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub);
        int waited = 0;
        IN_VALID = 1'b1; A = a; B = b; CIN = cin; SUB = sub;
        @(negedge CLK);
        while (!IN_READY && waited < 100) begin
            waited++;
            @(negedge CLK);
        end
        if (!IN_READY) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout: IN_READY=%b after %0d cycles, expected 1", IN_READY, waited);
        end
        @(posedge CLK);
        exp_q.push_back(model(a, b, cin, sub));
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = '0; B = '0; CIN = 1'b0; SUB = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({OUT_VALID, IN_READY, REZ, CarryOut, OVF, ZERO} !== {1'b1 ^ 1'b1, 1'b1, 16'h0, 3'b000}) begin
            n_errors++;
            $display("FAIL reset_state: OUT_VALID=%b IN_READY=%b REZ=%h C=%b V=%b Z=%b, expected 0 1 0000 0 0 0",
                     OUT_VALID, IN_READY, REZ, CarryOut, OVF, ZERO);
        end
        @(posedge CLK);
        #1;
    endtask

    // Latency check: the beat shows up exactly on the 5th negedge after the accepting edge
    task automatic check_latency(input string name, input logic [W-1:0] exp_rez);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_checks++;
            if (OUT_VALID !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_early: OUT_VALID=%b after %0d edges, expected 0", name, OUT_VALID, i);
            end
        end
        @(negedge CLK);
        n_checks++;
        if (OUT_VALID !== 1'b1 || REZ !== exp_rez) begin
            n_errors++;
            $display("FAIL %s_latency: OUT_VALID=%b REZ=%h, expected 1 %h", name, OUT_VALID, REZ, exp_rez);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single();
        drive_beat(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_checks++;
            if (OUT_VALID !== 1'b0) begin
                n_errors++;
                $display("FAIL single_early: OUT_VALID=%b after %0d edges, expected 0", OUT_VALID, i);
            end
        end
        @(negedge CLK);
        n_checks++;
        if ({OUT_VALID, REZ, CarryOut, OVF, ZERO} !== {1'b1, 16'h2201, 3'b000}) begin
            n_errors++;
            $display("FAIL single_result: V=%b REZ=%h C=%b O=%b Z=%b, expected 1 2201 0 0 0",
                     OUT_VALID, REZ, CarryOut, OVF, ZERO);
        end
        @(posedge CLK);
        #1;
        wait_drain();
    endtask

    task automatic check_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic [W+2:0] exp);
        int n = 0;
        @(posedge CLK);
        #1;
        drive_beat(a, b, 1'b0, sub);
        @(negedge CLK);
        while (OUT_VALID !== 1'b1 && n < 20) begin
            n++;
            @(negedge CLK);
        end
        n_checks++;
        if ({REZ, CarryOut, OVF, ZERO} !== exp || OUT_VALID !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: V=%b REZ=%h C=%b O=%b Z=%b, expected REZ=%h C=%b O=%b Z=%b", name,
                     OUT_VALID, REZ, CarryOut, OVF, ZERO, exp[W+2:3], exp[2], exp[1], exp[0]);
        end
        @(posedge CLK);
        #1;
        wait_drain();
    endtask

    task automatic test_wrap();
        check_directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        check_directed("sub_wrap", 16'h0000, 16'h0001, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b0});
`ifdef MBLEDHESI_SAT_EN
        check_directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});
        check_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0});
`else
        check_directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
        check_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
`endif
    endtask

    task automatic test_back_to_back();
        int base;
        @(posedge CLK);
        #1;
        base = n_popped;
        fork
            begin
                for (int i = 1; i <= 8; i++) drive_beat(W'(i), W'(i), 1'b0, 1'b0);
            end
            begin
                int n = 0;
                @(negedge CLK);
                while (OUT_VALID !== 1'b1 && n < 20) begin
                    n++;
                    @(negedge CLK);
                end
                for (int i = 0; i < 8; i++) begin
                    n_checks++;
                    if (OUT_VALID !== 1'b1 || REZ !== W'(2 * (i + 1))) begin
                        n_errors++;
                        $display("FAIL b2b_stream: beat %0d OUT_VALID=%b REZ=%h, expected 1 %h",
                                 i, OUT_VALID, REZ, W'(2 * (i + 1)));
                    end
                    @(negedge CLK);
                end
            end
        join
        wait_drain();
        n_checks++;
        if (n_popped - base != 8) begin
            n_errors++;
            $display("FAIL b2b_count: delivered %0d, expected 8", n_popped - base);
        end
    endtask

    task automatic test_stall();
        int base;
        @(posedge CLK);
        #1;
        base = n_popped;
        fork
            begin
                for (int i = 1; i <= 8; i++) drive_beat(W'(i), W'(i), 1'b0, 1'b0);
            end
            begin
                int n = 0;
                while (n_popped < base + 2 && n < 50) begin
                    @(posedge CLK);
                    n++;
                end
                #1 OUT_READY = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge CLK);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL stall_queue: no beat outstanding during stall, expected at least 1");
                    end else if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 ||
                                 {REZ, CarryOut, OVF, ZERO} !== exp_q[0]) begin
                        n_errors++;
                        $display("FAIL stall_hold: cycle %0d OUT_VALID=%b IN_READY=%b REZ=%h, expected 1 0 %h",
                                 i, OUT_VALID, IN_READY, REZ, exp_q[0][EW-1:3]);
                    end
                end
                @(posedge CLK);
                #1 OUT_READY = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (n_popped - base != 8) begin
            n_errors++;
            $display("FAIL stall_count: delivered %0d, expected 8", n_popped - base);
        end
    endtask

    task automatic test_reset_flush();
        @(posedge CLK);
        #1;
        drive_beat(16'h0101, 16'h0202, 1'b0, 1'b0);
        drive_beat(16'hAAAA, 16'h1111, 1'b1, 1'b1);
        drive_beat(16'h4000, 16'h4000, 1'b0, 1'b0);
        RST = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            n_checks++;
            if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_flush: cycle %0d OUT_VALID=%b IN_READY=%b, expected 0 1",
                         i, OUT_VALID, IN_READY);
            end
        end
        n_checks++;
        if ({REZ, CarryOut, OVF, ZERO} !== 19'h0) begin
            n_errors++;
            $display("FAIL reset_regs: REZ=%h C=%b O=%b Z=%b, expected 0000 0 0 0", REZ, CarryOut, OVF, ZERO);
        end
        @(posedge CLK);
        #1;
        drive_beat(16'h1111, 16'h2222, 1'b1, 1'b0);
        check_latency("post_reset", 16'h3334);
        wait_drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        @(posedge CLK);
        #1;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    drive_beat(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                done = 1'b1;
            end
            begin
                int n = 0;
                while (!done && n < 2000) begin
                    @(posedge CLK);
                    #1 OUT_READY = ($urandom_range(0, 3) != 0);
                    n++;
                end
                OUT_READY = 1'b1;
            end
        join
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_random();
        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
